// File: rtl/instr_fetch.sv
// Instruction fetch stage: a three-state FSM (fetch, hold, halt) that
// requests words from instruction memory, holds one instruction for the
// decode stage and redirects on branches.
//
// Optional feature: define INSTR_FETCH_ILLEGAL_CHECK_EN to decode each
// captured word and halt on unsupported instructions. Without it, illegal
// is tied low and the halt state is never entered.

module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        stall,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [5:0]  opCode,
   output logic [5:0]  func,
   output logic [31:0] pc_out,
   output logic        illegal
);

   typedef enum logic [1:0] {
      StFetch,
      StHold,
      StHalt
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic        capture_illegal;
   logic [31:0] redirect_pc;

   // Masking the whole target keeps every bit of the port in use.
   assign redirect_pc = branch_target & 32'hFFFF_FFFC;

`ifdef INSTR_FETCH_ILLEGAL_CHECK_EN
   // Supported subset: R-type add/sub/sll/srl/and/or/slt and a few I-types.
   function automatic logic is_legal(input logic [31:0] word);
      logic [5:0] op;
      logic [5:0] fn;
      logic       ok;
      op = word[31:26];
      fn = word[5:0];
      ok = 1'b0;
      if (op == 6'b000000) begin
         case (fn)
            6'b100000, 6'b100010, 6'b000000, 6'b000010,
            6'b100100, 6'b100101, 6'b101010: ok = 1'b1;
            default:                         ok = 1'b0;
         endcase
      end else begin
         case (op)
            6'b000100, 6'b001000, 6'b100011, 6'b101011,
            6'b100001, 6'b001100, 6'b001101: ok = 1'b1;
            default:                         ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

   assign capture_illegal = ~is_legal(imem_rdata);
   assign illegal         = (state_q == StHalt);
`else
   assign capture_illegal = 1'b0;
   assign illegal         = 1'b0;
`endif

   // Next-state logic: branch redirects win over ack and stall; halt is sticky.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      pc_out_d = pc_out_q;
      case (state_q)
         StFetch: begin
            if (branch_taken) begin
               pc_d = redirect_pc;
            end else if (imem_ack) begin
               instr_d  = imem_rdata;
               pc_out_d = pc_q;
               pc_d     = pc_q + 32'd4;
               state_d  = capture_illegal ? StHalt : StHold;
            end
         end
         StHold: begin
            if (branch_taken) begin
               pc_d    = redirect_pc;
               state_d = StFetch;
            end else if (!stall) begin
               state_d = StFetch;
            end
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            state_d = StFetch;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StFetch;
         pc_q     <= RESET_PC & 32'hFFFF_FFFC;
         instr_q  <= 32'h0;
         pc_out_q <= 32'h0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         pc_out_q <= pc_out_d;
      end
   end

   assign imem_req    = (state_q == StFetch);
   assign imem_addr   = pc_q;
   assign instr_valid = (state_q == StHold);
   assign instr       = instr_q;
   assign opCode      = instr_q[31:26];
   assign func        = instr_q[5:0];
   assign pc_out      = pc_out_q;

endmodule
